fnd_scan_controller: RTL and testbench

//  Display end of the 0..9999 counter datapath. Takes the binary count from the
//  up/down counter and drives a 4-digit multiplexed 7-segment (FND) display.

---
 rtl/fnd_pkg.sv | 63 ++++++
 rtl/bin2bcd_seq.sv | 67 ++++++
 rtl/fnd_scan_controller.sv | 104 ++++++++++
 tb/tb_fnd_scan_controller.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/fnd_pkg.sv
// Shared definitions for the 4-digit FND display path: segment codes,
// display limits, converter state encoding and small helper functions.
package fnd_pkg;

   localparam int NUM_DIGITS   = 4;
   localparam int MAX_VAL      = 9999;
   localparam int BIN_W        = 14;
   localparam int BCD_W        = 16;
   localparam int SHIFT_CYCLES = BIN_W;

   // Segment codes {dp,g,f,e,d,c,b,a}, active-low, decimal point off
   localparam logic [7:0] SEG_0     = 8'hC0;
   localparam logic [7:0] SEG_1     = 8'hF9;
   localparam logic [7:0] SEG_2     = 8'hA4;
   localparam logic [7:0] SEG_3     = 8'hB0;
   localparam logic [7:0] SEG_4     = 8'h99;
   localparam logic [7:0] SEG_5     = 8'h92;
   localparam logic [7:0] SEG_6     = 8'h82;
   localparam logic [7:0] SEG_7     = 8'hF8;
   localparam logic [7:0] SEG_8     = 8'h80;
   localparam logic [7:0] SEG_9     = 8'h90;
   localparam logic [7:0] SEG_DASH  = 8'hBF;
   localparam logic [7:0] SEG_BLANK = 8'hFF;

   typedef enum logic [1:0] {
      CONV_IDLE  = 2'd0,
      CONV_LOAD  = 2'd1,
      CONV_SHIFT = 2'd2,
      CONV_DONE  = 2'd3
   } conv_state_t;

   // Map one BCD digit to its segment pattern; non-decimal codes go dark
   function automatic logic [7:0] seg_decode(input logic [3:0] digit);
      logic [7:0] seg;
      case (digit)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
      return seg;
   endfunction

   // Double-dabble correction: any nibble of 5 or more gets +3 before the shift
   function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] bcd);
      logic [BCD_W-1:0] res;
      res = bcd;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (bcd[4*i +: 4] >= 4'd5) begin
            res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative 14-bit binary to 4-digit BCD converter (double dabble).
// One bit per clock: LOAD, fourteen SHIFT cycles, then DONE pulses for
// one cycle with the result on bcd and the converted input on snap.
module bin2bcd_seq
   import fnd_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [BIN_W-1:0] bin,
   output logic             done,
   output logic [BCD_W-1:0] bcd,
   output logic [BIN_W-1:0] snap
);

   localparam logic [3:0] SHIFT_LAST = 4'(SHIFT_CYCLES - 1);

   conv_state_t      state;
   logic [BIN_W-1:0] shreg;
   logic [BCD_W-1:0] acc;
   logic [3:0]       shift_cnt;

   assign bcd = acc;

   // Converter sequencer: snapshot input, shift it through the BCD accumulator, flag completion
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= CONV_IDLE;
         shreg     <= '0;
         acc       <= '0;
         shift_cnt <= '0;
         snap      <= '0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            CONV_IDLE: begin
               if (start) begin
                  state <= CONV_LOAD;
               end
            end
            CONV_LOAD: begin
               snap      <= bin;
               shreg     <= bin;
               acc       <= '0;
               shift_cnt <= '0;
               state     <= CONV_SHIFT;
            end
            CONV_SHIFT: begin
               {acc, shreg} <= {dabble_adjust(acc), shreg} << 1;
               shift_cnt    <= shift_cnt + 4'd1;
               if (shift_cnt == SHIFT_LAST) begin
                  state <= CONV_DONE;
                  done  <= 1'b1;
               end
            end
            CONV_DONE: begin
               state <= start ? CONV_LOAD : CONV_IDLE;
            end
            default: begin
               state <= CONV_IDLE;
            end
         endcase
      end
   end

endmodule

// File: rtl/fnd_scan_controller.sv
// 4-digit multiplexed 7-segment driver for the 0..9999 counter.
// A free-running converter refreshes the display registers every 16
// cycles; a prescaler steps the active digit at SCAN_HZ.
module fnd_scan_controller
   import fnd_pkg::*;
#(
   parameter int CLK_HZ   = 100_000_000,
   parameter int SCAN_HZ  = 1_000,
   parameter int LZ_BLANK = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [BIN_W-1:0] count_in,
   input  logic [3:0]       dp_en,
   output logic [3:0]       fnd_com,
   output logic [7:0]       fnd_data,
   output logic             ovf
);

   localparam int DIV   = CLK_HZ / SCAN_HZ;
   localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

   logic [PRE_W-1:0] prescaler;
   logic [1:0]       digit_idx;
   logic [BCD_W-1:0] disp_bcd;
   logic             conv_done;
   logic [BCD_W-1:0] conv_bcd;
   logic [BIN_W-1:0] conv_snap;
   logic [3:0]       lead_zero;
   logic [3:0]       cur_digit;
   logic [7:0]       seg_next;

   bin2bcd_seq u_bin2bcd (
      .clk   (clk),
      .rst   (rst),
      .start (1'b1),
      .bin   (count_in),
      .done  (conv_done),
      .bcd   (conv_bcd),
      .snap  (conv_snap)
   );

   // Digit dwell timer: advance to the next digit every DIV cycles
   always_ff @(posedge clk) begin
      if (!rst) begin
         prescaler <= '0;
         digit_idx <= 2'd0;
      end else if (prescaler == PRE_LAST) begin
         prescaler <= '0;
         digit_idx <= digit_idx + 2'd1;
      end else begin
         prescaler <= prescaler + 1'b1;
      end
   end

   // Latch a finished conversion; out-of-range snapshots only raise ovf
   always_ff @(posedge clk) begin
      if (!rst) begin
         disp_bcd <= '0;
         ovf      <= 1'b0;
      end else if (conv_done) begin
         if (32'(conv_snap) > MAX_VAL) begin
            ovf <= 1'b1;
         end else begin
            ovf      <= 1'b0;
            disp_bcd <= conv_bcd;
         end
      end
   end

   // A digit is a leading zero when it and every digit above it are zero; ones never blanks
   assign lead_zero[3] = (disp_bcd[15:12] == 4'd0);
   assign lead_zero[2] = lead_zero[3] && (disp_bcd[11:8] == 4'd0);
   assign lead_zero[1] = lead_zero[2] && (disp_bcd[7:4] == 4'd0);
   assign lead_zero[0] = 1'b0;

   assign cur_digit = disp_bcd[{digit_idx, 2'b00} +: 4];

   // Pick the pattern for the active digit: dash on overflow, optional blanking, then dp
   always_comb begin
      seg_next = seg_decode(cur_digit);
      if (ovf) begin
         seg_next = SEG_DASH;
      end else if ((LZ_BLANK != 0) && lead_zero[digit_idx]) begin
         seg_next = SEG_BLANK;
      end
      if (dp_en[digit_idx]) begin
         seg_next[7] = 1'b0;
      end
   end

   // Drive common and segment pins together so they never disagree for a cycle
   always_ff @(posedge clk) begin
      if (!rst) begin
         fnd_com  <= 4'hF;
         fnd_data <= SEG_BLANK;
      end else begin
         fnd_com  <= ~(4'b0001 << digit_idx);
         fnd_data <= seg_next;
      end
   end

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Bench for fnd_scan_controller: one instance without and one with
// leading-zero blanking, both compared every cycle against a timeline model.
module tb_fnd_scan_controller;

   localparam int DIV       = 10;
   localparam int PERIOD    = 16;
   localparam int FIRST_LD  = 2;
   localparam int FIRST_UPD = 17;

   logic        clk = 1'b0;
   logic        rst;
   logic [13:0] count_in;
   logic [3:0]  dp_en;
   logic [3:0]  com0, com1;
   logic [7:0]  data0, data1;
   logic        ovf0, ovf1;

   int compared   = 0;
   int mismatched = 0;

   int         edge_no = 0;
   int         pending = 0;
   int         shown   = 0;
   logic [3:0] exp_com   = 4'hF;
   logic [7:0] exp_data0 = 8'hFF;
   logic [7:0] exp_data1 = 8'hFF;
   logic       exp_ovf   = 1'b0;

   logic [7:0] seg_table [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                  8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

   fnd_scan_controller #(.CLK_HZ(1000), .SCAN_HZ(100), .LZ_BLANK(0)) dut0 (
      .clk(clk), .rst(rst), .count_in(count_in), .dp_en(dp_en),
      .fnd_com(com0), .fnd_data(data0), .ovf(ovf0)
   );

   fnd_scan_controller #(.CLK_HZ(1000), .SCAN_HZ(100), .LZ_BLANK(1)) dut1 (
      .clk(clk), .rst(rst), .count_in(count_in), .dp_en(dp_en),
      .fnd_com(com1), .fnd_data(data1), .ovf(ovf1)
   );

   always #5 clk = ~clk;

   // Pattern a digit position should show for a decimal value
   function automatic logic [7:0] expected_seg(input int v, input int idx,
                                               input logic [3:0] dp, input bit lz);
      int         p;
      logic [7:0] s;
      p = 1;
      for (int k = 0; k < idx; k++) p = p * 10;
      if (v > 9999)                     s = 8'hBF;
      else if (lz && idx > 0 && v < p)  s = 8'hFF;
      else                              s = seg_table[(v / p) % 10];
      if (dp[idx]) s[7] = 1'b0;
      return s;
   endfunction

   // Reference timeline: sample every 16 cycles, publish 15 cycles later, digit every DIV cycles
   always @(posedge clk) begin
      int idx;
      if (!rst) begin
         edge_no   = 0;
         pending   = 0;
         shown     = 0;
         exp_com   = 4'hF;
         exp_data0 = 8'hFF;
         exp_data1 = 8'hFF;
         exp_ovf   = 1'b0;
      end else begin
         edge_no   = edge_no + 1;
         idx       = ((edge_no - 1) / DIV) % 4;
         exp_com   = ~(4'b0001 << idx);
         exp_data0 = expected_seg(shown, idx, dp_en, 1'b0);
         exp_data1 = expected_seg(shown, idx, dp_en, 1'b1);
         if (edge_no >= FIRST_UPD && (edge_no - FIRST_UPD) % PERIOD == 0) shown = pending;
         if (edge_no >= FIRST_LD && (edge_no - FIRST_LD) % PERIOD == 0) pending = int'(count_in);
         exp_ovf = (shown > 9999);
      end
   end

   task automatic checkOutput(input string tag, input logic [7:0] observed,
                              input logic [7:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Compare both instances midway between rising edges
   always @(negedge clk) begin
      checkOutput("com0",  8'(com0),  8'(exp_com));
      checkOutput("data0", data0,     exp_data0);
      checkOutput("ovf0",  8'(ovf0),  8'(exp_ovf));
      checkOutput("com1",  8'(com1),  8'(exp_com));
      checkOutput("data1", data1,     exp_data1);
      checkOutput("ovf1",  8'(ovf1),  8'(exp_ovf));
   end

   task automatic applyStimulus(input logic [13:0] value, input logic [3:0] dp, input int cycles);
      count_in = value;
      dp_en    = dp;
      repeat (cycles) @(negedge clk);
   endtask

   task automatic applyReset(input int cycles);
      rst = 1'b0;
      repeat (cycles) @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      int         pick;
      logic [13:0] v;
      rst      = 1'b0;
      count_in = 14'd0;
      dp_en    = 4'd0;
      repeat (3) @(negedge clk);
      rst = 1'b1;

      applyStimulus(14'd0,     4'b0000, 40);
      applyStimulus(14'd1234,  4'b0000, 80);
      applyStimulus(14'd10000, 4'b0000, 50);
      applyStimulus(14'd16383, 4'b1010, 50);
      applyStimulus(14'd42,    4'b0000, 60);
      applyStimulus(14'd7,     4'b0000, 60);
      applyStimulus(14'd0,     4'b0000, 60);
      applyStimulus(14'd1005,  4'b0000, 60);
      applyStimulus(14'd9999,  4'b0000, 19);
      applyStimulus(14'd0,     4'b0100, 60);
      applyStimulus(14'd9999,  4'b0001, 24);
      applyReset(1);
      applyStimulus(14'd3120,  4'b0000, 60);

      for (int n = 0; n < 300; n++) begin
         pick = int'($urandom_range(0, 9));
         case (pick)
            0:       v = 14'd0;
            1:       v = 14'd9999;
            2:       v = 14'd10000;
            3:       v = 14'd16383;
            4:       v = 14'($urandom_range(0, 99));
            5:       v = 14'($urandom_range(10000, 16383));
            default: v = 14'($urandom_range(0, 9999));
         endcase
         if ($urandom_range(0, 19) == 0) applyReset(int'($urandom_range(1, 3)));
         applyStimulus(v, 4'($urandom_range(0, 15)), int'($urandom_range(1, 45)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
